// File: rtl/hazard_pkg.sv
// Shared definitions for the decode-stage hazard sequencer.
//   state_e   : sequencer states
//   CNT_BITS  : width of the flush / branch-wait down-counter (FLUSH_CYCLES <= 3)
//   NOP_INSTR : instruction word that a bubble or flush stands in for (addi x0,x0,0)
package hazard_pkg;

  typedef enum logic [2:0] {
    RUN,
    LDUSE,
    BRWAIT,
    FLUSH,
    COPWAIT
  } state_e;

  localparam int CNT_BITS = 2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_cmp.sv
// Register-dependency comparator: one pipeline destination against both ID sources.
// Ports:
//   rs1, rs2         : source registers of the instruction in ID
//   use_rs1, use_rs2 : the ID instruction actually reads that source
//   rd               : destination register of the older instruction
//   hit              : some used, non-x0 source equals rd
module hazard_cmp
  import hazard_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic [4:0] rd,
  output logic       hit
);

  logic hit_rs1;
  logic hit_rs2;

  // x0 is hardwired to zero, so a dependency on it is never a hazard.
  assign hit_rs1 = use_rs1 && (rs1 != 5'd0) && (rs1 == rd);
  assign hit_rs2 = use_rs2 && (rs2 != 5'd0) && (rs2 == rd);
  assign hit     = hit_rs1 || hit_rs2;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage pipeline sequencer: stall / bubble / flush decisions for load-use,
// branch operand hazards, EX redirects and the coprocessor start/done handshake.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   rs1, rs2, use_rs1/2      : ID sources and their use flags
//   br_ID, cop_ID            : ID instruction is a branch/JALR, or a coprocessor op
//   rd_ID_EX, wr_ID_EX, ld_ID_EX : EX-stage destination, write enable, load flag
//   rd_EX_MEM, ld_EX_MEM     : MEM-stage destination and load flag
//   B_J_EX                   : redirect taken in EX this cycle
//   cop_done                 : coprocessor completion pulse
//   stall_pc, stall_IF_ID, flush_IF_ID, bubble_ID_EX : pipeline controls (combinational)
//   cop_start                : one-cycle coprocessor start pulse
//   cop_err                  : sticky coprocessor timeout flag
//   stall_cnt                : saturating count of cycles with stall_pc high
//
// state   | meaning
// RUN     | normal issue; hazards are detected here and stall in the detecting cycle
// LDUSE   | cycle after the single load-use stall; behaves like RUN
// BRWAIT  | branch operand wait; stalls while cnt>0, re-evaluates as RUN at cnt=0
// FLUSH   | IF/ID flushed after a redirect until cnt runs out
// COPWAIT | stalled on the coprocessor until cop_done or timeout
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int COP_TIMEOUT  = 1024,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             br_ID,
  input  logic             cop_ID,
  input  logic [4:0]       rd_ID_EX,
  input  logic             wr_ID_EX,
  input  logic             ld_ID_EX,
  input  logic [4:0]       rd_EX_MEM,
  input  logic             ld_EX_MEM,
  input  logic             B_J_EX,
  input  logic             cop_done,
  output logic             stall_pc,
  output logic             stall_IF_ID,
  output logic             flush_IF_ID,
  output logic             bubble_ID_EX,
  output logic             cop_start,
  output logic             cop_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int                TMR_W    = $clog2(COP_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(COP_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                cop_err_q, cop_err_d;
  logic [CNT_W-1:0]    stall_cnt_q;

  logic hit_ex;
  logic hit_mem;

  hazard_cmp u_cmp_ex (
    .rs1     (rs1),
    .rs2     (rs2),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .rd      (rd_ID_EX),
    .hit     (hit_ex)
  );

  hazard_cmp u_cmp_mem (
    .rs1     (rs1),
    .rs2     (rs2),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .rd      (rd_EX_MEM),
    .hit     (hit_mem)
  );

  // Issue decision shared by RUN, LDUSE and an expired BRWAIT.
  state_e              run_next;
  logic [CNT_BITS-1:0] run_cnt;
  logic                run_stall;
  logic                run_start;

  always_comb begin
    run_next  = RUN;
    run_cnt   = '0;
    run_stall = 1'b0;
    run_start = 1'b0;
    if (cop_ID) begin
      run_next  = COPWAIT;
      run_stall = 1'b1;
      run_start = 1'b1;
    end else if (br_ID && hit_ex && wr_ID_EX) begin
      // A load result is one stage further away than an ALU result.
      run_next  = BRWAIT;
      run_stall = 1'b1;
      run_cnt   = ld_ID_EX ? CNT_BITS'(1) : '0;
    end else if (br_ID && hit_mem && ld_EX_MEM) begin
      run_next  = BRWAIT;
      run_stall = 1'b1;
    end else if (hit_ex && ld_ID_EX) begin
      run_next  = LDUSE;
      run_stall = 1'b1;
    end
  end

  logic stall;
  logic flush;
  logic start;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    cop_err_d = cop_err_q;
    stall     = 1'b0;
    flush     = 1'b0;
    start     = 1'b0;
    if (B_J_EX) begin
      // Redirect overrides everything, including an outstanding coprocessor wait.
      flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = CNT_BITS'(FLUSH_CYCLES - 1);
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        FLUSH: begin
          flush = 1'b1;
          cnt_d = cnt_q - CNT_BITS'(1);
          if (cnt_q <= CNT_BITS'(1)) state_d = RUN;
        end
        COPWAIT: begin
          if (cop_done) begin
            state_d = RUN;
          end else begin
            stall = 1'b1;
            if (tmr_q == '0) begin
              cop_err_d = 1'b1;
              state_d   = RUN;
            end else begin
              tmr_d = tmr_q - TMR_W'(1);
            end
          end
        end
        BRWAIT: begin
          if (cnt_q != '0) begin
            stall = 1'b1;
            cnt_d = cnt_q - CNT_BITS'(1);
          end else begin
            state_d = run_next;
            cnt_d   = run_cnt;
            tmr_d   = TMR_LOAD;
            stall   = run_stall;
            start   = run_start;
          end
        end
        default: begin
          state_d = run_next;
          cnt_d   = run_cnt;
          tmr_d   = TMR_LOAD;
          stall   = run_stall;
          start   = run_start;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      tmr_q       <= '0;
      cop_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      cop_err_q <= cop_err_d;
      if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // Outputs are forced low while reset is held so an abort is visible immediately.
  assign stall_pc     = stall & ~rst;
  assign bubble_ID_EX = stall & ~rst;
  assign stall_IF_ID  = stall & ~flush & ~rst;
  assign flush_IF_ID  = flush & ~rst;
  assign cop_start    = start & ~rst;
  assign cop_err      = cop_err_q;
  assign stall_cnt    = stall_cnt_q;

endmodule
